// File: rtl/wavegen_pkg.sv
// Shared types and constants for the multi-channel waveform generator:
// waveform encodings, config register addresses and sequencer states.
package wavegen_pkg;

   typedef enum logic [1:0] {
      SAWTOOTH = 2'd0,
      TRIANGLE = 2'd1,
      SQUARE   = 2'd2,
      MUTE     = 2'd3
   } wave_t;

   localparam logic [1:0] CFG_ADDR_INC  = 2'd0;
   localparam logic [1:0] CFG_ADDR_AMP  = 2'd1;
   localparam logic [1:0] CFG_ADDR_WAVE = 2'd2;
   localparam logic [1:0] CFG_ADDR_DUTY = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample shaping for one channel.
// Optional amplitude scaling is built only when WAVEGEN_AMPLITUDE_EN is defined.
module wave_shaper
   import wavegen_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_phase,
   input  wave_t                 i_wave,
   input  logic [DATA_WIDTH-1:0] i_duty,
`ifdef WAVEGEN_AMPLITUDE_EN
   input  logic [DATA_WIDTH-1:0] i_amp,
`endif
   output logic [DATA_WIDTH-1:0] o_sample
);

   logic [DATA_WIDTH-1:0] w_tri;
   logic [DATA_WIDTH-1:0] w_wave;

   // Doubling the phase folds the upper half back down into a falling ramp.
   assign w_tri = {i_phase[DATA_WIDTH-2:0], 1'b0};

   // Raw waveform selection
   always_comb begin
      w_wave = {DATA_WIDTH{1'b0}};
      case (i_wave)
         SAWTOOTH: w_wave = i_phase;
         TRIANGLE: w_wave = i_phase[DATA_WIDTH-1] ? ~w_tri : w_tri;
         SQUARE:   w_wave = (i_phase < i_duty) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
         MUTE:     w_wave = {DATA_WIDTH{1'b0}};
         default:  w_wave = {DATA_WIDTH{1'b0}};
      endcase
   end

`ifdef WAVEGEN_AMPLITUDE_EN
   logic [DATA_WIDTH:0]     w_amp_p1;
   logic [2*DATA_WIDTH-1:0] w_prod;

   // amp+1 makes an all-ones amplitude an exact unity gain after the shift.
   assign w_amp_p1 = {1'b0, i_amp} + {{DATA_WIDTH{1'b0}}, 1'b1};
   assign w_prod   = {{DATA_WIDTH{1'b0}}, w_wave} * {{(DATA_WIDTH-1){1'b0}}, w_amp_p1};
   assign o_sample = DATA_WIDTH'(w_prod >> DATA_WIDTH);
`else
   assign o_sample = w_wave;
`endif

endmodule

// File: rtl/multi_wave_generator.sv
// Multi-channel waveform generator: per-channel register file, sweep sequencer
// and registered sample output. Amplitude scaling enabled by WAVEGEN_AMPLITUDE_EN.
module multi_wave_generator
   import wavegen_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int CHANNELS   = 4,
   localparam int CH_W       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  next_data_strobe_i,
   input  logic                  cfg_valid_strobe_i,
   input  logic [CH_W-1:0]       cfg_channel_i,
   input  logic [1:0]            cfg_addr_i,
   input  logic [DATA_WIDTH-1:0] cfg_data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CH_W-1:0]       channel_o,
   output logic                  data_out_valid_strobe_o,
   output logic                  busy_o
);

   localparam logic [CH_W-1:0]       LAST_CH    = CH_W'(CHANNELS - 1);
   localparam logic [DATA_WIDTH-1:0] DUTY_RESET = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] r_phase [CHANNELS];
   logic [DATA_WIDTH-1:0] r_inc   [CHANNELS];
   wave_t                 r_wave  [CHANNELS];
   logic [DATA_WIDTH-1:0] r_duty  [CHANNELS];
`ifdef WAVEGEN_AMPLITUDE_EN
   logic [DATA_WIDTH-1:0] r_amp   [CHANNELS];
`endif

   seq_state_t            r_state;
   seq_state_t            w_next_state;
   logic [CH_W-1:0]       r_idx;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CH_W-1:0]       r_chan;
   logic                  r_valid;

   logic                  w_accept;
   logic                  w_process;
   logic                  w_cfg_ch_ok;
   logic [DATA_WIDTH-1:0] w_new_phase;
   logic [DATA_WIDTH-1:0] w_sample;

   assign w_cfg_ch_ok = (32'(cfg_channel_i) < 32'(CHANNELS));
   assign w_new_phase = r_phase[r_idx] + r_inc[r_idx];

   wave_shaper #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shaper (
      .i_phase  (w_new_phase),
      .i_wave   (r_wave[r_idx]),
      .i_duty   (r_duty[r_idx]),
`ifdef WAVEGEN_AMPLITUDE_EN
      .i_amp    (r_amp[r_idx]),
`endif
      .o_sample (w_sample)
   );

   // Sequencer next-state: one channel per cycle, then one drain cycle
   // so busy covers the last sample's valid cycle.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_process    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable_i && next_data_strobe_i) begin
               w_accept     = 1'b1;
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_process = 1'b1;
            if (r_idx == LAST_CH) begin
               w_next_state = ST_DRAIN;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_DRAIN: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Sequencer state, channel index and busy flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_idx   <= {CH_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         if (w_accept) begin
            r_idx <= {CH_W{1'b0}};
         end else if (w_process) begin
            r_idx <= r_idx + CH_W'(1);
         end
      end
   end

   // Config register file; a channel processed on the write edge sees the old value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_inc[i]  <= {DATA_WIDTH{1'b0}};
            r_wave[i] <= SAWTOOTH;
            r_duty[i] <= DUTY_RESET;
`ifdef WAVEGEN_AMPLITUDE_EN
            r_amp[i]  <= {DATA_WIDTH{1'b1}};
`endif
         end
      end else if (cfg_valid_strobe_i && w_cfg_ch_ok) begin
         case (cfg_addr_i)
            CFG_ADDR_INC:  r_inc[cfg_channel_i]  <= cfg_data_i;
`ifdef WAVEGEN_AMPLITUDE_EN
            CFG_ADDR_AMP:  r_amp[cfg_channel_i]  <= cfg_data_i;
`endif
            CFG_ADDR_WAVE: r_wave[cfg_channel_i] <= wave_t'(cfg_data_i[1:0]);
            CFG_ADDR_DUTY: r_duty[cfg_channel_i] <= cfg_data_i;
            default: ;
         endcase
      end
   end

   // Phase accumulators and registered sample output
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_phase[i] <= {DATA_WIDTH{1'b0}};
         end
         r_data  <= {DATA_WIDTH{1'b0}};
         r_chan  <= {CH_W{1'b0}};
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_process) begin
            r_phase[r_idx] <= w_new_phase;
            r_data         <= w_sample;
            r_chan         <= r_idx;
            r_valid        <= 1'b1;
         end
      end
   end

   assign data_o                  = r_data;
   assign channel_o               = r_chan;
   assign data_out_valid_strobe_o = r_valid;
   assign busy_o                  = r_busy;

endmodule
